// File: rtl/btb_predictor.sv
// btb_predictor: fully-associative branch target buffer with per-entry
// saturating direction counters.
//
// Fetch presents lookup_pc with lookup_en. One cycle later the registered
// pred_hit, pred_taken and pred_next_pc outputs carry the prediction. Resolved
// branches write back through the update_* port. A lookup and an update on the
// same edge do not interact: the lookup sees the table as it was before the edge.
//
// Replacement: the lowest-index invalid entry is filled first. Once the table
// is full, a round-robin pointer selects the victim.
//
// Parameters:
//   ENTRIES  number of entries (>= 2)
//   ADDR_W   PC/target width
//   CTR_W    direction counter width (>= 1)
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   lookup_en/pc    lookup request
//   pred_hit        registered: lookup_pc matched a valid entry
//   pred_taken      registered: hit and counter MSB set
//   pred_next_pc    registered: target if pred_taken, else lookup_pc + 4
//   update_valid    resolved-branch strobe, with update_pc/taken/target
//
// Optional feature (macro BTB_STATS_EN):
//   stat_lookups    saturating count of lookups
//   stat_hits       saturating count of lookups that hit
module btb_predictor #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_hits
`endif
);

    localparam int unsigned IdxW = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CtrMax  = '1;
    // New entries start weakly taken.
    localparam logic [CTR_W-1:0] CtrInit = CTR_W'(1) << (CTR_W - 1);
    localparam logic [IdxW-1:0]  RrLast  = IdxW'(ENTRIES - 1);

    // Table state. Only the valid bits and rr need a reset.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];
    logic [IdxW-1:0]    rr_q, rr_d;

    // Prediction registers.
    logic              pred_hit_q, pred_hit_d;
    logic              pred_taken_q, pred_taken_d;
    logic [ADDR_W-1:0] pred_next_pc_q, pred_next_pc_d;

    // Lookup match.
    logic              lk_hit;
    logic [IdxW-1:0]   lk_idx;
    logic [ADDR_W-1:0] lk_pc_plus4;

    // Update match and victim choice.
    logic              up_hit;
    logic [IdxW-1:0]   up_idx;
    logic              free_found;
    logic [IdxW-1:0]   free_idx;
    logic [IdxW-1:0]   victim_idx;

    // ------------------------------------------------------------------
    // Lookup: tags are unique, so at most one entry can match.
    // ------------------------------------------------------------------
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_pc)) begin
                lk_hit = 1'b1;
                lk_idx = IdxW'(i);
            end
        end
    end

    assign lk_pc_plus4 = lookup_pc + ADDR_W'(4);

    always_comb begin
        pred_hit_d     = pred_hit_q;
        pred_taken_d   = pred_taken_q;
        pred_next_pc_d = pred_next_pc_q;
        if (lookup_en) begin
            pred_hit_d     = lk_hit;
            pred_taken_d   = lk_hit && ctr_q[lk_idx][CTR_W-1];
            pred_next_pc_d = pred_taken_d ? target_q[lk_idx] : lk_pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Update match and victim selection.
    // ------------------------------------------------------------------
    always_comb begin
        up_hit = 1'b0;
        up_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == update_pc)) begin
                up_hit = 1'b1;
                up_idx = IdxW'(i);
            end
        end
    end

    // Scan from the top so the lowest invalid index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    assign victim_idx = free_found ? free_idx : rr_q;

    // ------------------------------------------------------------------
    // Table next state.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        rr_d     = rr_q;
        if (update_valid) begin
            if (up_hit) begin
                if (update_taken) begin
                    if (ctr_q[up_idx] != CtrMax) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
                    end
                    target_d[up_idx] = update_target;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (update_taken) begin
                valid_d[victim_idx]  = 1'b1;
                tag_d[victim_idx]    = update_pc;
                target_d[victim_idx] = update_target;
                ctr_d[victim_idx]    = CtrInit;
                // rr advances only when it actually chose the victim.
                if (!free_found) begin
                    rr_d = (rr_q == RrLast) ? '0 : rr_q + IdxW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= '0;
            rr_q           <= '0;
            pred_hit_q     <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_next_pc_q <= '0;
        end else begin
            valid_q        <= valid_d;
            rr_q           <= rr_d;
            pred_hit_q     <= pred_hit_d;
            pred_taken_q   <= pred_taken_d;
            pred_next_pc_q <= pred_next_pc_d;
        end
    end

    // Payload storage is qualified by valid_q and needs no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

    assign pred_hit     = pred_hit_q;
    assign pred_taken   = pred_taken_q;
    assign pred_next_pc = pred_next_pc_q;

`ifdef BTB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating lookup statistics.
    // ------------------------------------------------------------------
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] hits_q, hits_d;

    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        if (lookup_en) begin
            if (lookups_q != '1) begin
                lookups_d = lookups_q + 32'd1;
            end
            if (lk_hit && (hits_q != '1)) begin
                hits_d = hits_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
`endif

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters.
- Sits beside the fetch stage:
  - Fetch presents the current PC and gets a registered next-PC prediction one cycle later.
  - Execute/resolve writes back actual branch outcomes through a separate update port.
- Replacement: fill invalid entries first, then round-robin over valid entries.

Parameters:
- ENTRIES, 4, number of fully-associative entries (>=2).
- ADDR_W, 32, PC/target width.
- CTR_W, 2, direction counter width (>=1).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- lookup_en  input  1  perform lookup this cycle
- lookup_pc  input  ADDR_W  fetch PC to look up
- pred_hit  output  1  registered: lookup_pc matched a valid entry
- pred_taken  output  1  registered: hit and counter MSB = 1
- pred_next_pc  output  ADDR_W  registered: target if pred_taken, else lookup_pc+4
- update_valid  input  1  resolved branch write-back strobe
- update_pc  input  ADDR_W  PC of resolved branch
- update_taken  input  1  actual direction
- update_target  input  ADDR_W  actual target

Behaviour:
- Reset (async):
  - All valid bits = 0; round-robin pointer rr = 0.
  - pred_hit = 0, pred_taken = 0, pred_next_pc = 0.
  - Tag/target/counter storage need not be cleared.
  - Reset asserted mid-operation discards all entries.
- Lookup, 1-cycle latency:
  - At posedge with lookup_en = 1, compare lookup_pc against all valid tags.
  - Hit on entry i: pred_hit <= 1; pred_taken <= ctr[i][CTR_W-1]; pred_next_pc <= taken ? target[i] : lookup_pc+4.
  - Miss: pred_hit <= 0; pred_taken <= 0; pred_next_pc <= lookup_pc+4.
  - lookup_en = 0: all pred_* outputs hold.
  - The +4 add wraps modulo 2^ADDR_W.
- Lookup/update ordering:
  - Lookup sees table state before any update applied on the same edge. No bypass.
  - A same-cycle update to the looked-up PC is visible from the next lookup onward.
- Update, applied at posedge when update_valid = 1:
  - Hit on entry j, taken: ctr[j] increments, saturating at 2^CTR_W-1; target[j] <= update_target.
  - Hit on entry j, not taken: ctr[j] decrements, saturating at 0; target unchanged.
  - Miss and taken: allocate a victim and write tag = update_pc, target = update_target, ctr = 1<<(CTR_W-1) (weakly taken), valid = 1.
  - Miss and not taken: no allocation, no state change.
- Victim selection:
  - If any entry is invalid, use the lowest-index invalid entry; rr unchanged.
  - Otherwise use entry rr, then rr <= (rr==ENTRIES-1) ? 0 : rr+1.
- Tags are unique by construction: allocation happens only on a miss, so no duplicate entries exist.
- Width rules: rr is $clog2(ENTRIES) bits. Counters are unsigned CTR_W bits.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds two outputs.
  - stat_lookups (output, 32): increments on every posedge with lookup_en = 1.
  - stat_hits (output, 32): increments when that lookup hits.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then lookup 0x100 -> next cycle pred_hit=0, pred_taken=0, pred_next_pc=0x104. Lookup 0xFFFFFFFC -> pred_next_pc=0x00000000.
2. Update 0x100 taken, target 0x200 -> following lookup of 0x100 gives hit=1, taken=1, next_pc=0x200 (ctr=2'b10).
3. On entry 0x100:
   - Two not-taken updates -> ctr 01 then 00; lookup gives hit=1, taken=0, next_pc=0x104.
   - Third not-taken -> ctr stays 00.
   - Three taken updates -> ctr saturates at 11.
4. ENTRIES=4:
   - Allocate 0x100, 0x110, 0x120, 0x130 (all taken).
   - Allocate 0x140 -> replaces 0x100 (lookup 0x100 misses, 0x140 hits).
   - Allocate 0x150 -> replaces 0x110.
5. Same edge: lookup 0x300 and taken update 0x300 -> target 0x380. That lookup reports hit=0; next lookup of 0x300 reports hit=1, next_pc=0x380.
6. Not-taken update of unknown 0x400 -> no allocation, lookup misses. With BTB_STATS_EN: 10 lookups with 3 hits -> stat_lookups=10, stat_hits=3. Assert reset mid-run -> both counters = 0, all lookups miss.
